// File: rtl/i_arith_pkg.sv
// Shared definitions for the immediate-arithmetic sequencer: opcodes,
// ALU function codes, FSM states, control-word layout and a packer.
package i_arith_pkg;

   localparam logic [9:0] OP_ADDI  = 10'b1001000100;
   localparam logic [9:0] OP_ADDIS = 10'b1011000100;
   localparam logic [9:0] OP_SUBI  = 10'b1101000100;
   localparam logic [9:0] OP_SUBIS = 10'b1111000100;
   localparam logic [9:0] OP_ANDI  = 10'b1001001000;
   localparam logic [9:0] OP_ANDIS = 10'b1111001000;
   localparam logic [9:0] OP_ORRI  = 10'b1011001000;
   localparam logic [9:0] OP_EORI  = 10'b1101001000;
   localparam logic [8:0] OP_MOVZ  = 9'b110100101;
   localparam logic [8:0] OP_MOVK  = 9'b111100101;

   // alu_fs[4:2] function, [1] invert B + carry-in, [0] invert A
   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00100;
   localparam logic [4:0] ALU_ADD = 5'b01000;
   localparam logic [4:0] ALU_XOR = 5'b01100;
   localparam logic [4:0] ALU_SUB = 5'b01010;

   localparam logic [1:0] PC_FS_HOLD = 2'b00;
   localparam logic [1:0] PC_FS_INC  = 2'b01;
   localparam logic [1:0] NS_DONE    = 2'b00;
   localparam logic [1:0] NS_CONT    = 2'b01;

   localparam int CW_WIDTH       = 33;
   localparam int CW_NS          = 0;
   localparam int CW_STATUS_LOAD = 2;
   localparam int CW_PC_SEL      = 3;
   localparam int CW_PC_FS       = 4;
   localparam int CW_PC_EN       = 6;
   localparam int CW_RAM_W       = 7;
   localparam int CW_RAM_EN      = 8;
   localparam int CW_RF_W        = 9;
   localparam int CW_WA          = 10;
   localparam int CW_SB          = 15;
   localparam int CW_SA          = 20;
   localparam int CW_RF_B_EN     = 25;
   localparam int CW_ALU_FS      = 26;
   localparam int CW_ALU_BS      = 31;
   localparam int CW_ALU_EN      = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MASK = 2'd2
   } state_e;

   // Builds a control word; fields not listed are the same for every
   // legal step (ALU on, immediate B, register write, no memory).
   function automatic logic [CW_WIDTH-1:0] cw_pack(
      input logic [4:0] fs,
      input logic [4:0] sa,
      input logic [4:0] wa,
      input logic [1:0] pc_fs,
      input logic       sl,
      input logic [1:0] ns
   );
      logic [CW_WIDTH-1:0] c;
      c = '0;
      c[CW_ALU_EN]          = 1'b1;
      c[CW_ALU_BS]          = 1'b0;
      c[CW_ALU_FS +: 5]     = fs;
      c[CW_RF_B_EN]         = 1'b0;
      c[CW_SA +: 5]         = sa;
      c[CW_SB +: 5]         = 5'd0;
      c[CW_WA +: 5]         = wa;
      c[CW_RF_W]            = 1'b1;
      c[CW_RAM_EN]          = 1'b0;
      c[CW_RAM_W]           = 1'b0;
      c[CW_PC_EN]           = 1'b0;
      c[CW_PC_FS +: 2]      = pc_fs;
      c[CW_PC_SEL]          = 1'b1;
      c[CW_STATUS_LOAD]     = sl;
      c[CW_NS +: 2]         = ns;
      return c;
   endfunction

endpackage

// File: rtl/i_arith_field_decode.sv
// Combinational field decoder: instruction + step -> {cw, k, illegal}.
// Ports: i_instr, i_second (MOVK merge step), o_cw, o_k, o_illegal, o_multi.
module i_arith_field_decode
   import i_arith_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int IMM_WIDTH      = 12,
   parameter int WIDE_IMM_WIDTH = 16,
   parameter int ENABLE_MOVK    = 1
) (
   input  logic [31:0]           i_instr,
   input  logic                  i_second,
   output logic [CW_WIDTH-1:0]   o_cw,
   output logic [DATA_WIDTH-1:0] o_k,
   output logic                  o_illegal,
   output logic                  o_multi
);

   logic [9:0]  w_op10;
   logic [8:0]  w_op9;
   logic [1:0]  w_hw;
   logic [4:0]  w_rn;
   logic [4:0]  w_rd;
   logic [5:0]  w_shamt;
   logic [63:0] w_imm16;
   logic [63:0] w_ones16;
   logic [63:0] w_wide_val;
   logic [63:0] w_wide_mask;
   logic        w_hw_bad;
   logic        w_arith;
   logic        w_movz;
   logic        w_movk;
   logic [4:0]  w_fs;
   logic        w_setf;

   assign w_op10  = i_instr[31:22];
   assign w_op9   = i_instr[31:23];
   assign w_hw    = i_instr[22:21];
   assign w_rn    = i_instr[9:5];
   assign w_rd    = i_instr[4:0];
   assign w_shamt = {w_hw, 4'b0000};

   assign w_imm16  = {{(64-WIDE_IMM_WIDTH){1'b0}},
                      i_instr[5 +: WIDE_IMM_WIDTH]};
   assign w_ones16 = {{(64-WIDE_IMM_WIDTH){1'b0}},
                      {WIDE_IMM_WIDTH{1'b1}}};

   assign w_wide_val  = w_imm16 << w_shamt;
   assign w_wide_mask = ~(w_ones16 << w_shamt);

   // Upper halfwords do not exist on a 32-bit datapath
   assign w_hw_bad = (DATA_WIDTH == 32) && w_hw[1];

   assign w_movz = (w_op9 == OP_MOVZ) && !w_hw_bad;
   assign w_movk = (ENABLE_MOVK != 0) && (w_op9 == OP_MOVK)
                   && !w_hw_bad;

   always_comb begin
      w_arith = 1'b1;
      w_fs    = ALU_ADD;
      w_setf  = 1'b0;
      unique case (1'b1)
         (w_op10 == OP_ADDI):  w_fs = ALU_ADD;
         (w_op10 == OP_ADDIS): begin
            w_fs   = ALU_ADD;
            w_setf = 1'b1;
         end
         (w_op10 == OP_SUBI):  w_fs = ALU_SUB;
         (w_op10 == OP_SUBIS): begin
            w_fs   = ALU_SUB;
            w_setf = 1'b1;
         end
         (w_op10 == OP_ANDI):  w_fs = ALU_AND;
         (w_op10 == OP_ANDIS): begin
            w_fs   = ALU_AND;
            w_setf = 1'b1;
         end
         (w_op10 == OP_ORRI):  w_fs = ALU_OR;
         (w_op10 == OP_EORI):  w_fs = ALU_XOR;
         default:              w_arith = 1'b0;
      endcase
   end

   always_comb begin
      o_cw      = '0;
      o_k       = '0;
      o_illegal = 1'b0;
      o_multi   = 1'b0;
      unique case (1'b1)
         w_arith: begin
            o_cw = cw_pack(w_fs, w_rn, w_rd, PC_FS_INC,
                           w_setf, NS_DONE);
            o_k  = {{(DATA_WIDTH-IMM_WIDTH){1'b0}},
                    i_instr[10 +: IMM_WIDTH]};
         end
         w_movz: begin
            // OR with XZR places the shifted immediate
            o_cw = cw_pack(ALU_OR, 5'd31, w_rd, PC_FS_INC,
                           1'b0, NS_DONE);
            o_k  = w_wide_val[DATA_WIDTH-1:0];
         end
         (w_movk && !i_second): begin
            // Clear the target halfword, PC held for the merge
            o_cw    = cw_pack(ALU_AND, w_rd, w_rd, PC_FS_HOLD,
                              1'b0, NS_CONT);
            o_k     = w_wide_mask[DATA_WIDTH-1:0];
            o_multi = 1'b1;
         end
         (w_movk && i_second): begin
            o_cw = cw_pack(ALU_OR, w_rd, w_rd, PC_FS_INC,
                           1'b0, NS_DONE);
            o_k  = w_wide_val[DATA_WIDTH-1:0];
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/i_arith_sequencer.sv
// Registered immediate-arithmetic sequencer with two-step MOVK.
// Ports: clock, reset_n, instr_valid/instr/instr_ready, stall,
// cw_valid/cw/k (latency 1), busy (MOVK mask step), illegal (pulse).
module i_arith_sequencer
   import i_arith_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int IMM_WIDTH      = 12,
   parameter int WIDE_IMM_WIDTH = 16,
   parameter int ENABLE_MOVK    = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  instr_valid,
   input  logic [31:0]           instr,
   output logic                  instr_ready,
   input  logic                  stall,
   output logic                  cw_valid,
   output logic [32:0]           cw,
   output logic [DATA_WIDTH-1:0] k,
   output logic                  busy,
   output logic                  illegal
);

   state_e                r_state;
   state_e                w_next;
   logic [31:0]           r_instr;
   logic                  r_cw_valid;
   logic [32:0]           r_cw;
   logic [DATA_WIDTH-1:0] r_k;
   logic                  r_busy;
   logic                  r_illegal;

   logic                  w_accept;
   logic                  w_in_mask;
   logic [31:0]           w_dec_instr;
   logic [32:0]           w_dec_cw;
   logic [DATA_WIDTH-1:0] w_dec_k;
   logic                  w_dec_illegal;
   logic                  w_dec_multi;

   logic                  w_cw_valid;
   logic [32:0]           w_cw;
   logic [DATA_WIDTH-1:0] w_k;
   logic                  w_busy;
   logic                  w_illegal;

   assign instr_ready = !stall && (r_state == IDLE || r_state == EXEC);
   assign w_accept    = instr_valid && instr_ready;
   assign w_in_mask   = (r_state == MASK);

   // The merge step re-decodes the MOVK captured at acceptance
   assign w_dec_instr = w_in_mask ? r_instr : instr;

   i_arith_field_decode #(
      .DATA_WIDTH     (DATA_WIDTH),
      .IMM_WIDTH      (IMM_WIDTH),
      .WIDE_IMM_WIDTH (WIDE_IMM_WIDTH),
      .ENABLE_MOVK    (ENABLE_MOVK)
   ) u_dec (
      .i_instr   (w_dec_instr),
      .i_second  (w_in_mask),
      .o_cw      (w_dec_cw),
      .o_k       (w_dec_k),
      .o_illegal (w_dec_illegal),
      .o_multi   (w_dec_multi)
   );

   always_comb begin
      w_next     = r_state;
      w_cw_valid = 1'b0;
      w_cw       = '0;
      w_k        = '0;
      w_busy     = 1'b0;
      w_illegal  = 1'b0;
      if (w_in_mask) begin
         w_next     = EXEC;
         w_cw_valid = 1'b1;
         w_cw       = w_dec_cw;
         w_k        = w_dec_k;
      end else if (w_accept) begin
         if (w_dec_illegal) begin
            w_next    = IDLE;
            w_illegal = 1'b1;
         end else begin
            w_next     = w_dec_multi ? MASK : EXEC;
            w_cw_valid = 1'b1;
            w_cw       = w_dec_cw;
            w_k        = w_dec_k;
            w_busy     = w_dec_multi;
         end
      end else begin
         w_next = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_instr    <= '0;
         r_cw_valid <= 1'b0;
         r_cw       <= '0;
         r_k        <= '0;
         r_busy     <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (!stall) begin
         r_state    <= w_next;
         r_cw_valid <= w_cw_valid;
         r_cw       <= w_cw;
         r_k        <= w_k;
         r_busy     <= w_busy;
         r_illegal  <= w_illegal;
         if (w_accept) begin
            r_instr <= instr;
         end
      end
   end

   assign cw_valid = r_cw_valid;
   assign cw       = r_cw;
   assign k        = r_k;
   assign busy     = r_busy;
   assign illegal  = r_illegal;

endmodule

// File: tb/tb_i_arith_sequencer.sv
// Directed scoreboard bench for i_arith_sequencer (64-bit and 32-bit).
// Expected words are built from the field layout, independent of the RTL.
module tb_i_arith_sequencer;

   typedef struct {
      logic        v;
      logic [32:0] cw;
      logic [63:0] k;
      logic        b;
      logic        il;
   } exp_t;

   localparam logic [4:0] F_AND = 5'b00000;
   localparam logic [4:0] F_OR  = 5'b00100;
   localparam logic [4:0] F_ADD = 5'b01000;
   localparam logic [4:0] F_XOR = 5'b01100;
   localparam logic [4:0] F_SUB = 5'b01010;
   localparam logic [8:0] M_Z   = 9'b110100101;
   localparam logic [8:0] M_K   = 9'b111100101;
   localparam logic [31:0] ADDI_X3 = 32'h911FFCA3;

   logic        clock;
   logic        reset_n;
   logic        instr_valid, stall, instr_ready;
   logic [31:0] instr;
   logic        cw_valid, busy, illegal;
   logic [32:0] cw;
   logic [63:0] k;

   logic        v32, stall32, rdy32;
   logic [31:0] ins32;
   logic        cwv32, busy32, ill32;
   logic [32:0] cw32;
   logic [31:0] k32;

   int total = 0;
   int bad   = 0;
   exp_t sb[$];

   i_arith_sequencer #(.DATA_WIDTH(64)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .stall       (stall),
      .cw_valid    (cw_valid),
      .cw          (cw),
      .k           (k),
      .busy        (busy),
      .illegal     (illegal)
   );

   i_arith_sequencer #(.DATA_WIDTH(32)) dut32 (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr_valid (v32),
      .instr       (ins32),
      .instr_ready (rdy32),
      .stall       (stall32),
      .cw_valid    (cwv32),
      .cw          (cw32),
      .k           (k32),
      .busy        (busy32),
      .illegal     (ill32)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [32:0] cwx(
      input logic [4:0] fs, input logic [4:0] sa,
      input logic [4:0] wa, input logic [1:0] pcfs,
      input logic sl, input logic [1:0] ns);
      return {1'b1, 1'b0, fs, 1'b0, sa, 5'd0, wa,
              1'b1, 1'b0, 1'b0, 1'b0, pcfs, 1'b1, sl, ns};
   endfunction

   function automatic exp_t ex(input logic v, input logic [32:0] c,
      input logic [63:0] kk, input logic b, input logic il);
      exp_t e;
      e.v = v; e.cw = c; e.k = kk; e.b = b; e.il = il;
      return e;
   endfunction

   function automatic exp_t ex_idle();
      return ex(1'b0, 33'd0, 64'd0, 1'b0, 1'b0);
   endfunction

   function automatic exp_t ex_ill();
      return ex(1'b0, 33'd0, 64'd0, 1'b0, 1'b1);
   endfunction

   function automatic logic [31:0] ari(input logic [9:0] op,
      input logic [11:0] imm, input logic [4:0] rn, input logic [4:0] rd);
      return {op, imm, rn, rd};
   endfunction

   function automatic logic [31:0] mov(input logic [8:0] op,
      input logic [1:0] hw, input logic [15:0] imm, input logic [4:0] rd);
      return {op, hw, imm, rd};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic compare(input string tag, input logic v,
      input logic [32:0] c, input logic [63:0] kk, input logic b,
      input logic il);
      exp_t g;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s.queue observed=empty expected=entry", tag);
      end else begin
         g = sb.pop_front();
         chk({tag, ".cw_valid"}, 64'(v), 64'(g.v));
         chk({tag, ".cw"}, 64'(c), 64'(g.cw));
         chk({tag, ".k"}, kk, g.k);
         chk({tag, ".busy"}, 64'(b), 64'(g.b));
         chk({tag, ".illegal"}, 64'(il), 64'(g.il));
      end
   endtask

   task automatic step(input string tag, input logic v,
      input logic [31:0] ins, input logic st, input logic rdy,
      input exp_t e);
      instr_valid = v;
      instr       = ins;
      stall       = st;
      #1;
      chk({tag, ".ready"}, 64'(instr_ready), 64'(rdy));
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare(tag, cw_valid, cw, k, busy, illegal);
   endtask

   task automatic step32(input string tag, input logic v,
      input logic [31:0] ins, input logic rdy, input exp_t e);
      v32   = v;
      ins32 = ins;
      #1;
      chk({tag, ".ready"}, 64'(rdy32), 64'(rdy));
      sb.push_back(e);
      @(posedge clock);
      #1;
      compare(tag, cwv32, cw32, {32'd0, k32}, busy32, ill32);
   endtask

   initial begin
      exp_t e_addi, e_mk1;
      reset_n     = 1'b0;
      instr_valid = 1'b0;
      instr       = '0;
      stall       = 1'b0;
      v32         = 1'b0;
      ins32       = '0;
      stall32     = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("rst.cw_valid", 64'(cw_valid), 64'd0);
      chk("rst.cw", 64'(cw), 64'd0);
      chk("rst.k", k, 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.illegal", 64'(illegal), 64'd0);
      reset_n = 1'b1;

      e_addi = ex(1, cwx(F_ADD, 5, 3, 2'b01, 0, 2'b00), 64'h7FF, 0, 0);
      step("addi", 1, ADDI_X3, 0, 1, e_addi);
      step("subis", 1, ari(10'b1111000100, 12'd4, 2, 1), 0, 1,
           ex(1, cwx(F_SUB, 2, 1, 2'b01, 1, 2'b00), 64'd4, 0, 0));
      step("orri", 1, ari(10'b1011001000, 12'hABC, 10, 9), 0, 1,
           ex(1, cwx(F_OR, 10, 9, 2'b01, 0, 2'b00), 64'hABC, 0, 0));
      step("andis", 1, ari(10'b1111001000, 12'hFFF, 6, 4), 0, 1,
           ex(1, cwx(F_AND, 6, 4, 2'b01, 1, 2'b00), 64'hFFF, 0, 0));
      step("eori", 1, ari(10'b1101001000, 12'h001, 31, 0), 0, 1,
           ex(1, cwx(F_XOR, 31, 0, 2'b01, 0, 2'b00), 64'h1, 0, 0));
      step("addis", 1, ari(10'b1011000100, 12'h000, 1, 2), 0, 1,
           ex(1, cwx(F_ADD, 1, 2, 2'b01, 1, 2'b00), 64'h0, 0, 0));
      step("subi", 1, ari(10'b1101000100, 12'h800, 3, 3), 0, 1,
           ex(1, cwx(F_SUB, 3, 3, 2'b01, 0, 2'b00), 64'h800, 0, 0));
      step("andi", 1, ari(10'b1001001000, 12'h0F0, 7, 8), 0, 1,
           ex(1, cwx(F_AND, 7, 8, 2'b01, 0, 2'b00), 64'hF0, 0, 0));
      step("gap", 0, 32'd0, 0, 1, ex_idle());

      step("movz", 1, mov(M_Z, 2'd1, 16'h1234, 2), 0, 1,
           ex(1, cwx(F_OR, 31, 2, 2'b01, 0, 2'b00), 64'h12340000, 0, 0));
      step("movk.mask", 1, mov(M_K, 2'd2, 16'hBEEF, 7), 0, 1,
           ex(1, cwx(F_AND, 7, 7, 2'b00, 0, 2'b01),
              64'hFFFF0000FFFFFFFF, 1, 0));
      step("movk.exec", 1, ADDI_X3, 0, 0,
           ex(1, cwx(F_OR, 7, 7, 2'b01, 0, 2'b00),
              64'h0000BEEF00000000, 0, 0));
      step("addi.after.movk", 1, ADDI_X3, 0, 1, e_addi);
      step("hold.exec", 1, ari(10'b1111000100, 12'd4, 2, 1), 1, 0, e_addi);

      e_mk1 = ex(1, cwx(F_AND, 8, 8, 2'b00, 0, 2'b01),
                 64'hFFFFFFFFFFFF0000, 1, 0);
      step("movk2.mask", 1, mov(M_K, 2'd0, 16'h5555, 8), 0, 1, e_mk1);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("stall%0d", i), 0, 32'd0, 1, 0, e_mk1);
      end
      step("movk2.exec", 0, 32'd0, 0, 0,
           ex(1, cwx(F_OR, 8, 8, 2'b01, 0, 2'b00), 64'h5555, 0, 0));

      step("ill.op0", 1, 32'd0, 0, 1, ex_ill());
      step("ill.after", 0, 32'd0, 0, 1, ex_idle());

      step("movk3.mask", 1, mov(M_K, 2'd3, 16'h00FF, 9), 0, 1,
           ex(1, cwx(F_AND, 9, 9, 2'b00, 0, 2'b01),
              64'h0000FFFFFFFFFFFF, 1, 0));
      reset_n = 1'b0;
      step("rst.mask", 0, 32'd0, 0, 0, ex_idle());
      reset_n = 1'b1;
      step("addi.after.rst", 1, ADDI_X3, 0, 1, e_addi);
      step("idle64", 0, 32'd0, 0, 1, ex_idle());

      step32("w32.movz.hw2", 1, mov(M_Z, 2'd2, 16'hCAFE, 1), 1, ex_ill());
      step32("w32.after", 0, 32'd0, 1, ex_idle());
      step32("w32.movz.hw1", 1, mov(M_Z, 2'd1, 16'h1234, 3), 1,
             ex(1, cwx(F_OR, 31, 3, 2'b01, 0, 2'b00), 64'h12340000, 0, 0));
      step32("w32.movk.hw3", 1, mov(M_K, 2'd3, 16'h1111, 4), 1, ex_ill());
      step32("w32.op0", 1, 32'd0, 1, ex_ill());
      step32("w32.movk.mask", 1, mov(M_K, 2'd1, 16'hABCD, 5), 1,
             ex(1, cwx(F_AND, 5, 5, 2'b00, 0, 2'b01), 64'h0000FFFF, 1, 0));
      step32("w32.movk.exec", 0, 32'd0, 0,
             ex(1, cwx(F_OR, 5, 5, 2'b01, 0, 2'b00), 64'hABCD0000, 0, 0));
      step32("w32.idle", 0, 32'd0, 1, ex_idle());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i_arith_sequencer.md
Name: i_arith_sequencer

Overview:
- Registered, parametrised successor to the single-cycle immediate-arithmetic decoder in the control unit.
- Accepts one 32-bit I-format or IW-format instruction per handshake and emits the 33-bit control word plus a DATA_WIDTH constant `k`.
- Supports flag-setting variants, logical immediates and wide-immediate moves. MOVK is a two-step sequence: mask, then merge.
- Sits between the instruction register and the datapath control mux.

Parameters:
- DATA_WIDTH, 64, datapath and `k` width; legal values 32 or 64.
- IMM_WIDTH, 12, ALU-immediate field width, taken from instr[21:10] and zero-extended.
- WIDE_IMM_WIDTH, 16, MOV immediate field width, taken from instr[20:5].
- ENABLE_MOVK, 1, when 0 MOVK is decoded as illegal.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  instruction word.
- instr_ready  out  1  sequencer can accept this cycle.
- stall  in  1  downstream hold; freezes all registered outputs and state.
- cw_valid  out  1  `cw` and `k` valid this cycle.
- cw  out  33  control word. Field order MSB to LSB: alu_en, alu_bs, alu_fs[5], rf_b_en, sa[5], sb[5], wa[5], rf_w, ram_en, ram_w, pc_en, pc_fs[2], pc_sel, status_load, ns[2].
- k  out  DATA_WIDTH  constant for ALU B.
- busy  out  1  multi-step sequence in progress.
- illegal  out  1  one-cycle pulse on an unsupported opcode, or on hw>1 when DATA_WIDTH=32.

Behaviour:
- Reset (while reset_n=0 at the clock edge):
  - state goes to IDLE; cw_valid=0, cw=0, k=0, busy=0, illegal=0.
  - Any in-flight MOVK is abandoned.
- Handshake:
  - instr_ready = !stall && (state==IDLE || state==EXEC).
  - An instruction is accepted when instr_valid && instr_ready.
  - Outputs are registered with latency 1: cw_valid=1 in the cycle after acceptance.
  - Back-to-back single-step ops are accepted every cycle.
- States:
  - IDLE: cw_valid=0.
  - EXEC: final step.
  - MASK: MOVK step 1.
  - Transitions:
    - Accept of a single-step op, from IDLE or EXEC, goes to EXEC.
    - Accept of MOVK goes to MASK.
    - MASK goes to EXEC, unconditionally when !stall.
    - EXEC with no accept goes to IDLE.
  - stall=1 holds the state and every output unchanged.
- Opcodes (instr[31:22]):
  - 1001000100 ADDI, 1011000100 ADDIS, 1101000100 SUBI, 1111000100 SUBIS.
  - 1001001000 ANDI, 1111001000 ANDIS, 1011001000 ORRI, 1101001000 EORI.
  - MOV opcodes use instr[31:23]: 110100101 MOVZ, 111100101 MOVK.
  - hw = instr[22:21].
- alu_fs encoding:
  - alu_fs[4:2] selects the function: 000 and, 001 or, 010 add, 011 xor.
  - alu_fs[1] = invert B and carry-in; alu_fs[0] = invert A.
  - So add=01000, sub=01010.
- Common fields for all legal steps:
  - alu_en=1, alu_bs=0, rf_b_en=0, sb=0, rf_w=1, ram_en=0, ram_w=0, pc_en=0, pc_sel=1.
- Arithmetic/logical ops:
  - sa=Rn (instr[9:5]), wa=Rd (instr[4:0]).
  - k = zero-extended imm12.
  - status_load=1 only for the S variants.
  - pc_fs=01; ns=00.
- MOVZ:
  - alu_fs=00100 (or), sa=31 (XZR), wa=Rd.
  - k = imm16 << (16*hw), truncated to DATA_WIDTH.
  - status_load=0, pc_fs=01, ns=00.
- MOVK step MASK:
  - alu_fs=00000 (and), sa=Rd, wa=Rd.
  - k = ~(0xFFFF << 16*hw).
  - pc_fs=00 (PC hold), ns=01, busy=1.
- MOVK step EXEC:
  - alu_fs=00100, sa=Rd, wa=Rd.
  - k = imm16 << 16*hw.
  - pc_fs=01, ns=00.
  - busy=0.
- Illegal instruction:
  - The instruction is consumed.
  - Next cycle: illegal=1, cw_valid=0, cw=0, k=0.
  - state goes to IDLE.
- MOVK instruction timing: instr_ready=0 during MASK, so a new instruction can be accepted only in the MOVK EXEC cycle.

Decomposition:
- Package i_arith_pkg holds:
  - opcode localparams;
  - alu_fs constants (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB);
  - state encoding (IDLE, EXEC, MASK);
  - control-word field offsets;
  - PC_FS_HOLD and PC_FS_INC.
- One sub-module, i_arith_field_decode: purely combinational, mapping instr and step to {cw, k, illegal}. The top holds the FSM and output registers.

Test Plan:
- ADDI X3,X5,#0x7FF (instr=0x911FFCA3), no stall:
  - cycle+1: cw_valid=1, alu_fs=01000, sa=5, wa=3, k=0x7FF, status_load=0, pc_fs=01.
- SUBIS X1,X2,#4 followed by ORRI on the next cycle:
  - two consecutive cw_valid cycles.
  - First: alu_fs=01010, status_load=1.
  - Second: alu_fs=00100.
  - instr_ready=1 throughout.
- MOVK X7,#0xBEEF,LSL#32 (hw=2):
  - MASK cycle: k=0xFFFF0000FFFFFFFF, alu_fs=00000, pc_fs=00, busy=1, instr_ready=0.
  - EXEC cycle: k=0x0000BEEF00000000, alu_fs=00100, pc_fs=01.
- stall=1 held for 3 cycles during MASK:
  - cw and k are unchanged for all 3 cycles.
  - After stall drops, EXEC follows in the next cycle.
- DATA_WIDTH=32 with MOVZ hw=2, or opcode 0x000:
  - illegal=1 for one cycle, cw_valid=0, state returns to IDLE.
- reset_n=0 asserted during MASK:
  - next edge: cw_valid=0, busy=0, cw=0, k=0.
  - The following ADDI is accepted normally.
